// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor. The carry chain is cut into STAGES slices, with a
// signed-overflow flag, optional saturation and one global advance enable for backpressure.
module pipe_rca #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_rca: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end

    localparam int unsigned SW = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub ? 1'b1 : ci;

    // Intermediate stage k holds the low (k+1) sum slices plus the still-unadded operand bits.
    for (genvar k = 0; k < int'(STAGES) - 1; k++) begin : gen_stage
        localparam int unsigned Done = (k + 1) * SW;
        localparam int unsigned Rem  = WIDTH - Done;

        logic               v_in, c_in, sat_in;
        logic [Rem+SW-1:0]  a_in, b_in;
        logic [Done-1:0]    lo_in;
        logic [SW:0]        part;
        logic [Done-1:0]    sum_d;

        logic               v_q, c_q, sat_q;
        logic [Done-1:0]    sum_q;
        logic [Rem-1:0]     a_q, b_q;

        if (k == 0) begin : g_first
            assign v_in   = in_valid;
            assign c_in   = c_eff;
            assign sat_in = sat_en;
            assign a_in   = a;
            assign b_in   = b_eff;
            assign lo_in  = '0;
        end else begin : g_next
            assign v_in   = gen_stage[k-1].v_q;
            assign c_in   = gen_stage[k-1].c_q;
            assign sat_in = gen_stage[k-1].sat_q;
            assign a_in   = gen_stage[k-1].a_q;
            assign b_in   = gen_stage[k-1].b_q;
            assign lo_in  = Done'(gen_stage[k-1].sum_q);
        end

        assign part = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + (SW+1)'(c_in);

        always_comb begin
            sum_d = lo_in;
            sum_d[Done-1 -: SW] = part[SW-1:0];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q   <= v_in;
                c_q   <= part[SW];
                sat_q <= sat_in;
                sum_q <= sum_d;
                a_q   <= a_in[Rem+SW-1:SW];
                b_q   <= b_in[Rem+SW-1:SW];
            end
        end
    end

    logic             fin_valid, fin_sat, fin_c;
    logic [SW-1:0]    fin_a, fin_b;
    logic [WIDTH-1:0] fin_lo;

    if (STAGES == 1) begin : g_fin_direct
        assign fin_valid = in_valid;
        assign fin_sat   = sat_en;
        assign fin_c     = c_eff;
        assign fin_a     = a;
        assign fin_b     = b_eff;
        assign fin_lo    = '0;
    end else begin : g_fin_pipe
        assign fin_valid = gen_stage[STAGES-2].v_q;
        assign fin_sat   = gen_stage[STAGES-2].sat_q;
        assign fin_c     = gen_stage[STAGES-2].c_q;
        assign fin_a     = gen_stage[STAGES-2].a_q;
        assign fin_b     = gen_stage[STAGES-2].b_q;
        assign fin_lo    = WIDTH'(gen_stage[STAGES-2].sum_q);
    end

    logic [SW:0]      top;
    logic [WIDTH-1:0] raw_sum, sat_val, s_d;
    logic             a_msb, cin_msb, ovf_d;

    assign top     = {1'b0, fin_a} + {1'b0, fin_b} + (SW+1)'(fin_c);
    assign a_msb   = fin_a[SW-1];
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign cin_msb = fin_a[SW-1] ^ fin_b[SW-1] ^ top[SW-1];
    assign ovf_d   = cin_msb ^ top[SW];
    assign sat_val = a_msb ? (WIDTH'(1) << (WIDTH - 1)) : ~(WIDTH'(1) << (WIDTH - 1));

    always_comb begin
        raw_sum = fin_lo;
        raw_sum[WIDTH-1 -: SW] = top[SW-1:0];
        s_d = (fin_sat && ovf_d) ? sat_val : raw_sum;
    end

    logic             out_valid_q, co_q, ovf_q;
    logic [WIDTH-1:0] s_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= fin_valid;
            if (fin_valid) begin
                s_q   <= s_d;
                co_q  <= top[SW];
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/pipe_rca.md
# pipe_rca

Parametrised, pipelined ripple-carry adder/subtractor for the FIR datapath, generalising the fixed 16-bit combinational adder. A WIDTH-bit carry chain is split into STAGES equal slices, with one register stage per slice, so the chain length per cycle is WIDTH/STAGES bits. It adds a subtract mode, a signed-overflow flag, optional saturation, and a valid/ready handshake with backpressure. It sits between the tap multipliers and the accumulator tree.

## Interface
- WIDTH, 16, operand and sum width in bits.
- STAGES, 4, number of pipeline slices. WIDTH % STAGES == 0 and 1 <= STAGES <= WIDTH; any other value is an elaboration error.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat is present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A (two's complement for ovf/saturation).
- b  input  WIDTH  operand B.
- ci  input  1  carry-in. Ignored when sub=1.
- sub  input  1  1: compute a - b as a + ~b + 1.
- sat_en  input  1  1: clamp the signed result on overflow.
- out_valid  output  1  result beat is present.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum/difference, registered.
- co  output  1  raw carry-out of the MSB. In sub mode this is the not-borrow.
- ovf  output  1  signed overflow, equal to carry-into-MSB XOR co. Reported whether or not sat_en is set.

## Operation
- Slice k covers bits [(k+1)*WIDTH/STAGES-1 : k*WIDTH/STAGES].
- Stage k adds slice k, using the carry registered by stage k-1. Stage 0 uses the effective carry-in: sub ? 1 : ci.
- Operand bits of slices not yet added travel down the pipe, skewed, together with the sub and sat_en flags for that beat.
- Sum bits already produced are delayed so that all slices align at the output.
- The final stage also registers carry-into-MSB, co, ovf and the saturated or raw sum.
- Saturation applies only when sat_en=1 and ovf=1:
  - s = 0 followed by WIDTH-1 ones (0x7FFF) if the MSB of effective A is 0.
  - s = 1 followed by WIDTH-1 zeros (0x8000) if that MSB is 1.
  - co and ovf always report the raw values.
- Flags (sub, sat_en) are latched per beat. Beats with different modes may be mixed back-to-back.
- Flow control uses one global advance enable:
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - All stage registers, including per-stage valid bits, load only when adv=1.
  - When adv=0, every stage holds, including s, co, ovf and out_valid.
- Accept happens on in_valid && in_ready. If in_ready=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Beats are never dropped, duplicated or reordered.

## Timing
- Reset, sampled on the clk edge while rst_n=0:
  - All stage valid bits are cleared.
  - s=0, co=0, ovf=0, out_valid=0.
  - in_ready=1 from the first cycle after reset, provided out_ready is don't-care.
- Latency: a beat accepted in cycle n shows out_valid=1 in cycle n+STAGES when no stall occurs. Each stall cycle adds one cycle.
- STAGES=1 gives a single registered adder with a latency of 1.
- Throughput is one beat per cycle while out_ready=1.
- out_valid=1 and out_ready=0: the output holds stable, and in_ready=0 in the same cycle (combinational from out_ready).
- A full pipe with out_ready asserted accepts a new beat in the same cycle as the one retiring.
- Reset mid-operation discards all in-flight beats. No stale result appears after rst_n returns high.
- In-flight carry chains spanning all slices, for example 0xFFFF+1, must propagate correctly across stage boundaries.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Basic add: a=0x1234, b=0x4321, ci=0, sub=0 accepted in cycle n -> in cycle n+4, out_valid=1, s=0x5555, co=0, ovf=0.
- Carry across slices: a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, ovf=0. Then a=0x00FF, b=0x0000, ci=1 -> s=0x0100, co=0.
- Saturation: a=0x7FFF, b=0x0001 with sat_en=1 -> s=0x7FFF, ovf=1, co=0. The same operands with sat_en=0 -> s=0x8000, ovf=1.
- Subtract: a=0x8000, b=0x0001, sub=1, sat_en=1 -> s=0x8000, ovf=1, co=1. With sat_en=0 -> s=0x7FFF. Then a=0x0003, b=0x0005, sub=1 -> s=0xFFFE, co=0, ovf=0.
- Backpressure: 8 consecutive beats with i+1 added to 0x0100*i (i=0..7); drop out_ready for 3 cycles once out_valid rises. Expected:
  - in_ready=0 and outputs frozen during the stall.
  - All 8 results appear in order, with none lost or duplicated.
- Reset mid-stream: 3 beats in flight, then rst_n=0 for 1 cycle. Expected:
  - Next cycle: out_valid=0, s=0, co=0, ovf=0, in_ready=1.
  - No result for the discarded beats ever appears. A new beat then returns after 4 cycles.
